// File: rtl/multicycle_control.sv
// multicycle_control: multicycle FSM sequencing ALU, unified memory and register file for the MIPS subset.
// Optional MULTICYCLE_RETIRE_CNT_EN adds a retired-instruction counter output.
module multicycle_control #(
  parameter int STATE_W = 4,
  parameter int RA_REG  = 31
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       ir_write,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       reg_write,
  output logic [1:0] reg_dst,
  output logic [1:0] mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_op,
  output logic       ext_zero,
  output logic [1:0] pc_src,
  output logic       illegal
`ifdef MULTICYCLE_RETIRE_CNT_EN
  ,output logic [31:0] retired
`endif
);
  typedef enum logic [STATE_W-1:0] {
    FETCH = 0, DECODE = 1, MEM_ADDR = 2, MEM_RD = 3, MEM_WB = 4, MEM_WR = 5,
    EXEC_R = 6, WB_R = 7, EXEC_I = 8, WB_I = 9, BRANCH = 10, JUMP = 11,
    JAL = 12, JR = 13, ILLEGAL = 14
  } state_e;
  localparam logic [5:0] OP_R = 6'h00, OP_J = 6'h02, OP_JAL = 6'h03, OP_BEQ = 6'h04;
  localparam logic [5:0] OP_BNE = 6'h05, OP_ADDI = 6'h08, OP_XORI = 6'h0e;
  localparam logic [5:0] OP_LW = 6'h23, OP_SW = 6'h2b;
  localparam logic [5:0] F_ADD = 6'h20, F_SUB = 6'h22, F_SLT = 6'h2a, F_JR = 6'h08;
  if (RA_REG != 31) begin : g_ra_chk
    $error("multicycle_control: datapath link register decode assumes r31");
  end
  state_e state_q, state_d, dec_d;
  logic   r_op, is_xori;
  assign r_op    = opcode == OP_R;
  assign is_xori = opcode == OP_XORI;
  assign dec_d = (opcode == OP_LW || opcode == OP_SW) ? MEM_ADDR :
                 (r_op && (funct == F_ADD || funct == F_SUB || funct == F_SLT)) ? EXEC_R :
                 (r_op && funct == F_JR) ? JR :
                 (opcode == OP_J) ? JUMP :
                 (opcode == OP_JAL) ? JAL :
                 (opcode == OP_BEQ || opcode == OP_BNE) ? BRANCH :
                 (opcode == OP_ADDI || is_xori) ? EXEC_I : ILLEGAL;
  always_comb begin
    state_d = FETCH;
    case (state_q)
      FETCH:    state_d = mem_ready ? DECODE : FETCH;
      DECODE:   state_d = dec_d;
      MEM_ADDR: state_d = (opcode == OP_SW) ? MEM_WR : MEM_RD;
      MEM_RD:   state_d = mem_ready ? MEM_WB : MEM_RD;
      MEM_WR:   state_d = mem_ready ? FETCH : MEM_WR;
      EXEC_R:   state_d = WB_R;
      EXEC_I:   state_d = WB_I;
      ILLEGAL:  state_d = ILLEGAL;
      default:  state_d = FETCH;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state_q <= FETCH;
    else        state_q <= state_d;
  // Decode is gated by rst_n so requests drop the instant reset asserts.
  always_comb begin
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    iord       = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 2'd0;
    mem_to_reg = 2'd0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'd0;
    alu_op     = 3'd0;
    ext_zero   = 1'b0;
    pc_src     = 2'd0;
    illegal    = 1'b0;
    if (rst_n)
      case (state_q)
        FETCH: begin
          mem_read  = 1'b1;
          alu_src_b = 2'd1;
          ir_write  = mem_ready;
          pc_write  = mem_ready;
        end
        DECODE:   alu_src_b = 2'd3;
        MEM_ADDR: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'd2;
        end
        MEM_RD: begin
          mem_read = 1'b1;
          iord     = 1'b1;
        end
        MEM_WB: begin
          reg_write  = 1'b1;
          mem_to_reg = 2'd1;
        end
        MEM_WR: begin
          mem_write = 1'b1;
          iord      = 1'b1;
        end
        EXEC_R: begin
          alu_src_a = 1'b1;
          alu_op    = (funct == F_SUB) ? 3'd1 : (funct == F_SLT) ? 3'd3 : 3'd0;
        end
        WB_R: begin
          reg_write = 1'b1;
          reg_dst   = 2'd1;
        end
        EXEC_I: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'd2;
          ext_zero  = is_xori;
          alu_op    = is_xori ? 3'd2 : 3'd0;
        end
        WB_I:     reg_write = 1'b1;
        BRANCH: begin
          alu_src_a = 1'b1;
          alu_op    = 3'd1;
          pc_src    = 2'd1;
          pc_write  = (opcode == OP_BEQ && zero) || (opcode == OP_BNE && !zero);
        end
        JUMP: begin
          pc_src   = 2'd2;
          pc_write = 1'b1;
        end
        JAL: begin
          pc_src     = 2'd2;
          pc_write   = 1'b1;
          reg_write  = 1'b1;
          reg_dst    = 2'd2;
          mem_to_reg = 2'd2;
        end
        JR: begin
          pc_src   = 2'd3;
          pc_write = 1'b1;
        end
        ILLEGAL:  illegal = 1'b1;
        default:  ;
      endcase
  end
`ifdef MULTICYCLE_RETIRE_CNT_EN
  logic [31:0] retired_q;
  logic        final_st;
  assign final_st = state_q inside {MEM_WB, MEM_WR, WB_R, WB_I, BRANCH, JUMP, JAL, JR};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)                              retired_q <= '0;
    else if (final_st && state_d == FETCH) retired_q <= retired_q + 32'd1;
  assign retired = retired_q;
`endif
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: directed instruction sequences checked cycle by cycle against expected control bundles.
module tb_multicycle_control;
  logic       clk = 1'b0, rst_n = 1'b0;
  logic [5:0] opcode = '0, funct = '0;
  logic       zero = 1'b0, mem_ready = 1'b1;
  logic       pc_write, ir_write, iord, mem_read, mem_write, reg_write, alu_src_a, ext_zero, illegal;
  logic [1:0] reg_dst, mem_to_reg, alu_src_b, pc_src;
  logic [2:0] alu_op;
`ifdef MULTICYCLE_RETIRE_CNT_EN
  logic [31:0] retired;
`endif
  int tests = 0, fails = 0;
  int unsigned ret_exp = 0;
  logic [19:0] sb[$];
  logic [19:0] outs;
  multicycle_control dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero), .mem_ready(mem_ready),
    .pc_write(pc_write), .ir_write(ir_write), .iord(iord), .mem_read(mem_read), .mem_write(mem_write),
    .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .ext_zero(ext_zero), .pc_src(pc_src), .illegal(illegal)
`ifdef MULTICYCLE_RETIRE_CNT_EN
    , .retired(retired)
`endif
  );
  always #5 clk = ~clk;
  assign outs = {pc_write, ir_write, iord, mem_read, mem_write, reg_write, reg_dst, mem_to_reg,
                 alu_src_a, alu_src_b, alu_op, ext_zero, pc_src, illegal};
  function automatic logic [19:0] o(logic pcw, logic irw, logic io, logic mr, logic mw, logic rw,
                                    logic [1:0] rd, logic [1:0] m2r, logic a, logic [1:0] b,
                                    logic [2:0] op, logic ez, logic [1:0] ps, logic ill);
    return {pcw, irw, io, mr, mw, rw, rd, m2r, a, b, op, ez, ps, ill};
  endfunction
  task automatic cmp(input string tag);
    logic [19:0] e;
    e = sb.pop_front();
    tests++;
    assert (outs === e) else begin
      fails++;
      $error("FAIL %s got %h exp %h", tag, outs, e);
    end
`ifdef MULTICYCLE_RETIRE_CNT_EN
    tests++;
    assert (retired === ret_exp) else begin
      fails++;
      $error("FAIL %s_retired got %0d exp %0d", tag, retired, ret_exp);
    end
`endif
  endtask
  task automatic chk(input string tag, input logic [19:0] e);
    sb.push_back(e);
    @(negedge clk);
    cmp(tag);
    @(posedge clk);
    #1;
  endtask
  task automatic set(input logic [5:0] op, input logic [5:0] fn);
    opcode = op;
    funct  = fn;
  endtask
  logic [19:0] RST, F_RDY, F_WAIT, DEC, MADDR, MRD, MWB, MWR, WBR, WBI, ILL, J_O, JAL_O, JR_O;
  initial begin
    RST    = '0;
    F_RDY  = o(1,1,0,1,0,0,0,0,0,1,0,0,0,0);
    F_WAIT = o(0,0,0,1,0,0,0,0,0,1,0,0,0,0);
    DEC    = o(0,0,0,0,0,0,0,0,0,3,0,0,0,0);
    MADDR  = o(0,0,0,0,0,0,0,0,1,2,0,0,0,0);
    MRD    = o(0,0,1,1,0,0,0,0,0,0,0,0,0,0);
    MWB    = o(0,0,0,0,0,1,0,1,0,0,0,0,0,0);
    MWR    = o(0,0,1,0,1,0,0,0,0,0,0,0,0,0);
    WBR    = o(0,0,0,0,0,1,1,0,0,0,0,0,0,0);
    WBI    = o(0,0,0,0,0,1,0,0,0,0,0,0,0,0);
    ILL    = o(0,0,0,0,0,0,0,0,0,0,0,0,0,1);
    J_O    = o(1,0,0,0,0,0,0,0,0,0,0,0,2,0);
    JAL_O  = o(1,0,0,0,0,1,2,2,0,0,0,0,2,0);
    JR_O   = o(1,0,0,0,0,0,0,0,0,0,0,0,3,0);
    #3;
    sb.push_back(RST);
    cmp("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    set(6'h00, 6'h20);
    chk("add_f", F_RDY); chk("add_d", DEC);
    chk("add_ex", o(0,0,0,0,0,0,0,0,1,0,0,0,0,0)); chk("add_wb", WBR); ret_exp++;
    set(6'h00, 6'h22);
    chk("sub_f", F_RDY); chk("sub_d", DEC);
    chk("sub_ex", o(0,0,0,0,0,0,0,0,1,0,1,0,0,0)); chk("sub_wb", WBR); ret_exp++;
    set(6'h00, 6'h2a);
    chk("slt_f", F_RDY); chk("slt_d", DEC);
    chk("slt_ex", o(0,0,0,0,0,0,0,0,1,0,3,0,0,0)); chk("slt_wb", WBR); ret_exp++;
    set(6'h23, 6'h00);
    mem_ready = 1'b0;
    chk("fetch_wait0", F_WAIT); chk("fetch_wait1", F_WAIT);
    mem_ready = 1'b1;
    chk("lw_f", F_RDY); chk("lw_d", DEC); chk("lw_addr", MADDR);
    mem_ready = 1'b0;
    chk("lw_rd0", MRD); chk("lw_rd1", MRD);
    mem_ready = 1'b1;
    chk("lw_rd2", MRD); chk("lw_wb", MWB); ret_exp++;
    set(6'h0e, 6'h3f);
    chk("xori_f", F_RDY); chk("xori_d", DEC);
    chk("xori_ex", o(0,0,0,0,0,0,0,0,1,2,2,1,0,0)); chk("xori_wb", WBI); ret_exp++;
    set(6'h08, 6'h00);
    chk("addi_f", F_RDY); chk("addi_d", DEC);
    chk("addi_ex", o(0,0,0,0,0,0,0,0,1,2,0,0,0,0)); chk("addi_wb", WBI); ret_exp++;
    set(6'h04, 6'h00); zero = 1'b1;
    chk("beq_t_f", F_RDY); chk("beq_t_d", DEC);
    chk("beq_t_br", o(1,0,0,0,0,0,0,0,1,0,1,0,1,0)); ret_exp++;
    set(6'h05, 6'h00);
    chk("bne_nt_f", F_RDY); chk("bne_nt_d", DEC);
    chk("bne_nt_br", o(0,0,0,0,0,0,0,0,1,0,1,0,1,0)); ret_exp++;
    zero = 1'b0;
    chk("bne_t_f", F_RDY); chk("bne_t_d", DEC);
    chk("bne_t_br", o(1,0,0,0,0,0,0,0,1,0,1,0,1,0)); ret_exp++;
    set(6'h04, 6'h00);
    chk("beq_nt_f", F_RDY); chk("beq_nt_d", DEC);
    chk("beq_nt_br", o(0,0,0,0,0,0,0,0,1,0,1,0,1,0)); ret_exp++;
    set(6'h02, 6'h00);
    chk("j_f", F_RDY); chk("j_d", DEC); chk("j_x", J_O); ret_exp++;
    set(6'h03, 6'h00);
    chk("jal_f", F_RDY); chk("jal_d", DEC); chk("jal_x", JAL_O); ret_exp++;
    set(6'h00, 6'h08);
    chk("jr_f", F_RDY); chk("jr_d", DEC); chk("jr_x", JR_O); ret_exp++;
    set(6'h2b, 6'h00);
    chk("sw_f", F_RDY); chk("sw_d", DEC); chk("sw_addr", MADDR); chk("sw_wr", MWR); ret_exp++;
    chk("sw2_f", F_RDY); chk("sw2_d", DEC); chk("sw2_addr", MADDR);
    mem_ready = 1'b0;
    chk("sw2_wr", MWR);
    #2;
    rst_n = 1'b0;
    ret_exp = 0;
    #1;
    sb.push_back(RST);
    cmp("async_rst");
    @(posedge clk); #1;
    rst_n = 1'b1;
    mem_ready = 1'b1;
    set(6'h3f, 6'h00);
    chk("post_rst_f", F_RDY); chk("ill_d", DEC);
    for (int i = 0; i < 11; i++) begin
      mem_ready = i[0];
      zero = i[1];
      chk($sformatf("ill_%0d", i), ILL);
    end
    #2;
    rst_n = 1'b0;
    ret_exp = 0;
    #1;
    sb.push_back(RST);
    cmp("ill_rst");
    @(posedge clk); #1;
    rst_n = 1'b1;
    mem_ready = 1'b1;
    set(6'h00, 6'h20);
    chk("restart_f", F_RDY); chk("restart_d", DEC);
    chk("restart_ex", o(0,0,0,0,0,0,0,0,1,0,0,0,0,0)); chk("restart_wb", WBR); ret_exp++;
    chk("restart_f2", F_RDY);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Multicycle control FSM for the MIPS-subset CPU.
- Sequences one shared ALU, one unified instruction/data memory and the register file over several cycles per instruction.
- Supported instructions: LW, SW, J, JR, JAL, BEQ, BNE, XORI, ADDI, ADD, SUB, SLT.
- Sits between the instruction register (opcode/funct inputs) and the datapath muxes and write enables. Stalls on a memory ready handshake.

Parameters:
- STATE_W, 4, width of the state register.
- RA_REG, 31, link register index; informational, drives the reg_dst=2 decode in the datapath.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- opcode  in  6  IR[31:26].
- funct  in  6  IR[5:0].
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory completes current access this cycle.
- pc_write  out  1  load PC.
- ir_write  out  1  load IR.
- iord  out  1  memory address source: 0=PC, 1=ALUOut.
- mem_read  out  1  memory read request.
- mem_write  out  1  memory write request.
- reg_write  out  1  register file write enable.
- reg_dst  out  2  destination register: 0=rt, 1=rd, 2=r31.
- mem_to_reg  out  2  write-back data: 0=ALUOut, 1=MDR, 2=PC.
- alu_src_a  out  1  ALU A input: 0=PC, 1=regA.
- alu_src_b  out  2  ALU B input: 0=regB, 1=const 4, 2=ext imm, 3=sext imm<<2.
- alu_op  out  3  0=add, 1=sub, 2=xor, 3=slt.
- ext_zero  out  1  1 selects zero-extend of the immediate (XORI).
- pc_src  out  2  PC source: 0=ALU result, 1=ALUOut, 2=jump target, 3=regA.
- illegal  out  1  sticky undecodable-instruction flag.

Behaviour:
- State register updates on posedge clk; cleared asynchronously on rst_n low.
- While rst_n=0: state=FETCH, illegal=0, and pc_write, ir_write, mem_read, mem_write, reg_write all forced 0. All other outputs 0.
- Outputs are a decode of the state (Moore), except that pc_write/ir_write in FETCH and pc_write in BRANCH also depend on inputs. Any output not listed for a state is 0.
- FETCH:
  - mem_read=1, iord=0, alu_src_a=0, alu_src_b=1, alu_op=add.
  - If mem_ready: ir_write=1, pc_write=1, pc_src=0, go to DECODE. Otherwise hold in FETCH.
- DECODE: alu_src_a=0, alu_src_b=3, alu_op=add (branch target into ALUOut). Next state:
  - LW/SW -> MEM_ADDR.
  - opcode 0: funct 0x20/0x22/0x2a -> EXEC_R; funct 0x08 -> JR.
  - J -> JUMP; JAL -> JAL; BEQ/BNE -> BRANCH; ADDI/XORI -> EXEC_I.
  - Anything else -> ILLEGAL.
- MEM_ADDR: alu_src_a=1, alu_src_b=2, add. LW -> MEM_RD; SW -> MEM_WR.
- MEM_RD: mem_read=1, iord=1; hold until mem_ready, then MEM_WB.
- MEM_WB: reg_write=1, reg_dst=0, mem_to_reg=1 -> FETCH.
- MEM_WR: mem_write=1, iord=1; hold until mem_ready, then FETCH.
- EXEC_R: alu_src_a=1, alu_src_b=0, alu_op from funct (add/sub/slt) -> WB_R.
- WB_R: reg_write=1, reg_dst=1, mem_to_reg=0 -> FETCH.
- EXEC_I: alu_src_a=1, alu_src_b=2. ADDI: alu_op=add, ext_zero=0. XORI: alu_op=xor, ext_zero=1. -> WB_I.
- WB_I: reg_write=1, reg_dst=0, mem_to_reg=0 -> FETCH.
- BRANCH: alu_src_a=1, alu_src_b=0, sub, pc_src=1. pc_write = (BEQ & zero) | (BNE & ~zero). -> FETCH.
- JUMP: pc_src=2, pc_write=1 -> FETCH.
- JAL: pc_src=2, pc_write=1, reg_write=1, reg_dst=2, mem_to_reg=2 -> FETCH. The PC already holds PC+4 at this point.
- JR: pc_src=3, pc_write=1 -> FETCH.
- ILLEGAL: illegal=1. No writes or memory requests. Remains in ILLEGAL until reset.
- Latency with mem_ready high: FETCH and DECODE take 1 cycle each.
  - Total cycles: J/JR/JAL/BEQ/BNE=3, R-type/ADDI/XORI=4, SW=4, LW=5.
  - Each cycle of mem_ready=0 adds one cycle.
- opcode/funct must be stable from DECODE until the instruction's last state; the IR is written only in FETCH, so this holds.
- mem_read and mem_write are never both 1 in the same cycle.
- Unused state encodings -> FETCH on the next edge, with no writes.

Optional Feature:
- Macro: MULTICYCLE_RETIRE_CNT_EN.
- Defined: adds output retired[31:0], reset to 0 by rst_n.
  - Increments by 1 on every clock edge that leaves a final state (MEM_WB, MEM_WR, WB_R, WB_I, BRANCH, JUMP, JAL, JR) for FETCH.
  - Wraps from 0xFFFFFFFF to 0.
  - ILLEGAL never counts.
- Undefined: port absent, no counter logic.

Test Plan:
- ADD (opcode 0, funct 0x20), mem_ready=1 -> 4 cycles. reg_write=1 and reg_dst=1 only in cycle 4. alu_op=0 in EXEC_R. Back in FETCH at cycle 5.
- LW with mem_ready low for 2 cycles in MEM_RD -> 7 cycles total. mem_read=1 and iord=1 held for 3 cycles. Then MEM_WB with mem_to_reg=1, reg_dst=0.
- BEQ with zero=1 -> pc_write=1, pc_src=1 in cycle 3. BNE with zero=1 -> pc_write=0 in cycle 3, and no reg_write in any cycle.
- JAL -> cycle 3 asserts pc_write=1, pc_src=2, reg_write=1, reg_dst=2, mem_to_reg=2, all simultaneously.
- Opcode 0x3F -> illegal=1 from cycle 3. illegal stays 1 and all write enables stay 0 for 10+ cycles. rst_n pulse clears illegal and restarts in FETCH.
- rst_n low asynchronously mid-MEM_WR -> mem_write drops without waiting for a clock edge. After release: FETCH, and retired (if enabled) = 0.
